// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and registered status.
module fifo #(
    parameter int unsigned BITS = 8,
    parameter int unsigned SIZE = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [BITS-1:0]       wr_data,
    input  logic                  rd_en,
    output logic [BITS-1:0]       rd_data,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [$clog2(SIZE):0] fill
);

    localparam int unsigned AW = $clog2(SIZE);

    logic [BITS-1:0] mem [SIZE];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fill_nx;
    logic            do_wr;
    logic            do_rd;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign do_wr = wr_en && !fifo_full;
    assign do_rd = rd_en && !fifo_empty;

    always_comb begin
        fill_nx = fill;
        if (do_wr && !do_rd)
            fill_nx = fill + (AW+1)'(1);
        else if (!do_wr && do_rd)
            fill_nx = fill - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
        if (do_rd)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            fill       <= fill_nx;
            fifo_empty <= (fill_nx == '0);
            fifo_full  <= (fill_nx == (AW+1)'(SIZE));
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Frame serializer: start/data/ready handshake in, 8N1 (or 8E1 with UART_TX_PARITY_EN) out.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BITS         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] data,
    output logic            ready_c,
    output logic            tx,
    output logic            busy
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = cnt_width(BITS);

    tx_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [BITS-1:0]  shift;
    logic [BITS-1:0]  shift_nx;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign shift_nx = shift >> 1;
    // A new frame may be accepted from IDLE or on the last cycle of the stop bit.
    assign ready_c  = (state == ST_IDLE) || ((state == ST_STOP) && bit_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
                cnt <= bit_done ? '0 : cnt + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift   <= data;
                    cnt     <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    busy    <= 1'b1;
                    state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                    parity  <= ^data;
`endif
                end
                ST_START: begin
                    if (bit_done) begin
                        tx    <= shift[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift <= shift_nx;
                        if (bit_idx == IDX_W'(BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shift_nx[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        state <= start ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with cts flow control; parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned BAUDRATE = 115_200,
    parameter int unsigned BITS     = 8,
    parameter int unsigned SIZE     = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [BITS-1:0]       wr_data,
    input  logic                  cts,
    output logic                  tx,
    output logic                  busy,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [$clog2(SIZE):0] fill
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);

    logic            cts_meta;
    logic            cts_s;
    logic            ready_c;
    logic            pop_c;
    logic [BITS-1:0] rd_data;

    // cts comes straight from the host connector.
    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            cts_meta <= cts;
            cts_s    <= cts_meta;
        end
    end

    assign pop_c = ready_c && !fifo_empty && cts_s;

    fifo #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop_c),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fill       (fill)
    );

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BITS         (BITS)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .start   (pop_c),
        .data    (rd_data),
        .ready_c (ready_c),
        .tx      (tx),
        .busy    (busy)
    );

endmodule
